// File: rtl/mul_div_if.sv
// mul_div_if: request/result bundle between the execute stage and the
// multiply/divide unit.
//   master (pipeline side): drives start/op/inA/inB and the mthi/mtlo
//                           write port (hi_wen/lo_wen/wd); observes status.
//   slave  (mul_div_unit) : returns busy/done/div_by_zero and the HI/LO
//                           register contents.
interface mul_div_if #(
    parameter int N = 32
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] inA;
    logic [N-1:0] inB;
    logic         hi_wen;
    logic         lo_wen;
    logic [N-1:0] wd;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [N-1:0] hi;
    logic [N-1:0] lo;

    modport master (
        output start, op, inA, inB, hi_wen, lo_wen, wd,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, inA, inB, hi_wen, lo_wen, wd,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit with the HI/LO registers.
// One result bit per clock; an operation takes N+1 cycles from start.
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous active-high reset
//   bus (slave)  start/op/inA/inB request, hi_wen/lo_wen/wd direct writes,
//                busy/done/div_by_zero status, hi/lo results
// op: 00 mult, 01 multu, 10 div, 11 divu.
module mul_div_unit #(
    parameter int N = 32
) (
    input  logic      clock,
    input  logic      reset,
    mul_div_if.slave  bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [1:0]     op_q;
    logic [N-1:0]   b_q;       // |multiplicand| or |divisor|
    logic [N-1:0]   acc_q;     // product high half / partial remainder
    logic [N-1:0]   q_q;       // multiplier shifting out / quotient shifting in
    logic           q_neg_q;   // product or quotient must be negated
    logic           r_neg_q;   // remainder must be negated (dividend sign)
    logic           dz_q;
    logic           busy_q, done_q, dzo_q;
    logic [N-1:0]   hi_q, lo_q;

    // Operand magnitudes; only the signed ops (op[0]==0) see negative values.
    logic           a_neg, b_neg;
    logic [N-1:0]   a_mag, b_mag;
    assign a_neg = ~bus.op[0] & bus.inA[N-1];
    assign b_neg = ~bus.op[0] & bus.inB[N-1];
    assign a_mag = a_neg ? (~bus.inA + 1'b1) : bus.inA;
    assign b_mag = b_neg ? (~bus.inB + 1'b1) : bus.inB;

    // Multiply step: conditional add into the high half, then shift the
    // {carry, acc, q} chain right by one.
    logic [N:0]     mul_sum_d;
    assign mul_sum_d = {1'b0, acc_q} + {1'b0, (q_q[0] ? b_q : {N{1'b0}})};

    // Restoring divide step. Because the remainder stays below the divisor,
    // the N-bit wrapped difference is exact whenever the subtract succeeds.
    // With a zero divisor every step "succeeds", leaving quotient = all ones
    // and remainder = |dividend|.
    logic [N:0]     div_sh_d;
    logic [N-1:0]   div_diff_d;
    logic           div_ge_d;
    assign div_sh_d   = {acc_q, q_q[N-1]};
    assign div_diff_d = div_sh_d[N-1:0] - b_q;
    assign div_ge_d   = (div_sh_d >= {1'b0, b_q});

    // Sign corrections applied in FIX. Negating the most negative value
    // wraps to itself, which gives the required div overflow result.
    logic [2*N-1:0] prod_d, prod_fix_d;
    logic [N-1:0]   quot_fix_d, rem_fix_d;
    assign prod_d     = {acc_q, q_q};
    assign prod_fix_d = q_neg_q ? (~prod_d + 1'b1) : prod_d;
    assign quot_fix_d = q_neg_q ? (~q_q + 1'b1) : q_q;
    assign rem_fix_d  = r_neg_q ? (~acc_q + 1'b1) : acc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dzo_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            dzo_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.hi_wen) hi_q <= bus.wd;
                    if (bus.lo_wen) lo_q <= bus.wd;
                    if (bus.start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        op_q    <= bus.op;
                        b_q     <= b_mag;
                        acc_q   <= '0;
                        q_q     <= a_mag;
                        q_neg_q <= a_neg ^ b_neg;
                        r_neg_q <= a_neg;
                        dz_q    <= bus.op[1] & (bus.inB == '0);
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (op_q[1]) begin
                        acc_q <= div_ge_d ? div_diff_d : div_sh_d[N-1:0];
                        q_q   <= {q_q[N-2:0], div_ge_d};
                    end else begin
                        acc_q <= mul_sum_d[N:1];
                        q_q   <= {mul_sum_d[0], q_q[N-1:1]};
                    end
                    if (cnt_q == CW'(N-1)) state_q <= FIX;
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    dzo_q   <= dz_q;
                    if (op_q[1]) begin
                        lo_q <= dz_q ? {N{1'b1}} : quot_fix_d;
                        hi_q <= rem_fix_d;
                    end else begin
                        {hi_q, lo_q} <= prod_fix_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dzo_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mul_div_if #(.N(32)) bus ();
    mul_div_unit #(.N(32)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // Reference: plain integer arithmetic on the architectural definition.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, b,
                                  output logic [31:0] h, l, output logic z);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'd0, a} * {32'd0, b};
        sa = $signed(a);
        sb = $signed(b);
        z  = 1'b0;
        h  = '0;
        l  = '0;
        case (o)
            2'd0: {h, l} = sp;
            2'd1: {h, l} = up;
            2'd2: begin
                if (b == 0) begin h = a; l = '1; z = 1'b1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin h = 0; l = a; end
                else begin l = 32'(sa / sb); h = 32'(sa % sb); end
            end
            default: begin
                if (b == 0) begin h = a; l = '1; z = 1'b1; end
                else begin l = a / b; h = a % b; end
            end
        endcase
    endfunction

    task automatic idle_inputs();
        bus.start = 0; bus.op = 0; bus.inA = 0; bus.inB = 0;
        bus.hi_wen = 0; bus.lo_wen = 0; bus.wd = 0;
    endtask

    // Presents one operation in the current cycle (called #1 after an edge),
    // scrambles the operand inputs after capture, and waits (bounded) for done.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, b,
                         output int lat, output bit busy_ok,
                         output logic [31:0] h, l, output logic z);
        bus.start = 1; bus.op = o; bus.inA = a; bus.inB = b;
        @(posedge clock); #1;
        bus.start = 0; bus.op = 2'($urandom); bus.inA = $urandom; bus.inB = $urandom;
        lat = 0;
        busy_ok = 1;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy !== 1'b1) busy_ok = 0;
            @(posedge clock); #1;
            lat++;
        end
        if (bus.busy !== 1'b0) busy_ok = 0;
        h = bus.hi; l = bus.lo; z = bus.div_by_zero;
    endtask

    task automatic test_reset();
        bus.start = 1; bus.op = 2'd1; bus.inA = 32'h5; bus.inB = 32'h7;
        bus.hi_wen = 1; bus.lo_wen = 1; bus.wd = 32'hCAFE;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo} !== 67'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
                     bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo);
        end
        idle_inputs();
        reset = 0;
        @(posedge clock); #1;
    endtask

    task automatic test_multu_max();
        int lat; bit bok; logic [31:0] h, l; logic z;
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bok, h, l, z);
        checks++;
        if (lat !== 33 || !bok) begin
            errors++;
            $display("FAIL multu_latency: got lat=%0d busy_ok=%0d want 33/1", lat, bok);
        end
        checks++;
        if ({h, l, z} !== {32'hFFFF_FFFE, 32'h0000_0001, 1'b0}) begin
            errors++;
            $display("FAIL multu_max: got hi=%h lo=%h dz=%b want FFFFFFFE 00000001 0", h, l, z);
        end
    endtask

    task automatic test_signed();
        int lat; bit bok; logic [31:0] h, l; logic z;
        do_op(2'd0, 32'hFFFF_FFFD, 32'd5, lat, bok, h, l, z);
        checks++;
        if ({h, l} !== {32'hFFFF_FFFF, 32'hFFFF_FFF1} || lat !== 33) begin
            errors++;
            $display("FAIL mult_neg: got hi=%h lo=%h lat=%0d want FFFFFFFF FFFFFFF1 33", h, l, lat);
        end
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, lat, bok, h, l, z);
        checks++;
        if ({h, l, z} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}) begin
            errors++;
            $display("FAIL div_neg: got hi=%h lo=%h dz=%b want FFFFFFFF FFFFFFFD 0", h, l, z);
        end
    endtask

    task automatic test_div_zero();
        int lat; bit bok; logic [31:0] h, l; logic z;
        do_op(2'd3, 32'd100, 32'd0, lat, bok, h, l, z);
        checks++;
        if ({h, l, z} !== {32'h0000_0064, 32'hFFFF_FFFF, 1'b1} || lat !== 33) begin
            errors++;
            $display("FAIL divu_zero: got hi=%h lo=%h dz=%b lat=%0d want 64 FFFFFFFF 1 33", h, l, z, lat);
        end
        @(posedge clock); #1;
        checks++;
        if (bus.div_by_zero !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL dz_pulse: got dz=%b done=%b after done cycle want 0 0", bus.div_by_zero, bus.done);
        end
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, bok, h, l, z);
        checks++;
        if ({h, l, z} !== {32'h0, 32'h8000_0000, 1'b0}) begin
            errors++;
            $display("FAIL div_overflow: got hi=%h lo=%h dz=%b want 0 80000000 0", h, l, z);
        end
        do_op(2'd2, 32'hFFFF_FFF0, 32'd0, lat, bok, h, l, z);
        checks++;
        if ({h, l, z} !== {32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1}) begin
            errors++;
            $display("FAIL div_zero_neg: got hi=%h lo=%h dz=%b want FFFFFFF0 FFFFFFFF 1", h, l, z);
        end
    endtask

    task automatic test_busy_ignore();
        int lat; bit hold_ok; logic [31:0] h0, l0;
        bus.start = 1; bus.op = 2'd3; bus.inA = 32'd1000; bus.inB = 32'd7;
        @(posedge clock); #1;
        h0 = bus.hi; l0 = bus.lo;
        hold_ok = 1;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (lat < 6) begin
                bus.start = 1; bus.op = 2'd1; bus.inA = $urandom; bus.inB = $urandom;
                bus.hi_wen = 1; bus.lo_wen = 1; bus.wd = 32'h1234;
            end else begin
                idle_inputs();
            end
            if (bus.hi !== h0 || bus.lo !== l0) hold_ok = 0;
            @(posedge clock); #1;
            lat++;
        end
        idle_inputs();
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL hold_during_run: hi/lo changed while busy (hi=%h lo=%h)", bus.hi, bus.lo);
        end
        checks++;
        if ({bus.hi, bus.lo} !== {32'd6, 32'd142} || lat !== 33) begin
            errors++;
            $display("FAIL busy_ignore: got hi=%h lo=%h lat=%0d want 6 142 33", bus.hi, bus.lo, lat);
        end
        bus.hi_wen = 1; bus.wd = 32'h1234;
        @(posedge clock); #1;
        bus.hi_wen = 0; bus.lo_wen = 1; bus.wd = 32'h5678;
        @(posedge clock); #1;
        bus.lo_wen = 0;
        checks++;
        if ({bus.hi, bus.lo} !== {32'h1234, 32'h5678}) begin
            errors++;
            $display("FAIL mthi_mtlo: got hi=%h lo=%h want 1234 5678", bus.hi, bus.lo);
        end
        bus.hi_wen = 1; bus.lo_wen = 1; bus.wd = 32'hABCD;
        @(posedge clock); #1;
        idle_inputs();
        checks++;
        if ({bus.hi, bus.lo} !== {32'hABCD, 32'hABCD}) begin
            errors++;
            $display("FAIL both_wen: got hi=%h lo=%h want ABCD ABCD", bus.hi, bus.lo);
        end
    endtask

    task automatic test_write_with_start();
        int lat; logic [31:0] h;
        bus.start = 1; bus.op = 2'd1; bus.inA = 32'd3; bus.inB = 32'd4;
        bus.hi_wen = 1; bus.wd = 32'hDEAD;
        @(posedge clock); #1;
        idle_inputs();
        h = bus.hi;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        checks++;
        if (h !== 32'hDEAD || {bus.hi, bus.lo} !== {32'd0, 32'd12}) begin
            errors++;
            $display("FAIL write_with_start: got hi@start=%h hi=%h lo=%h want DEAD 0 C", h, bus.hi, bus.lo);
        end
    endtask

    task automatic test_reset_abort();
        int lat; bit bok, saw_done; logic [31:0] h, l, eh, el; logic z, ez;
        bus.start = 1; bus.op = 2'd3; bus.inA = 32'd99999; bus.inB = 32'd13;
        @(posedge clock); #1;
        bus.start = 0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        checks++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'd0) begin
            errors++;
            $display("FAIL reset_abort: got busy=%b done=%b hi=%h lo=%h want 0", bus.busy, bus.done, bus.hi, bus.lo);
        end
        saw_done = 0;
        repeat (40) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1;
            @(posedge clock); #1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_no_done: got activity after aborted op want none");
        end
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        do_op(2'd3, 32'd99999, 32'd13, lat, bok, h, l, z);
        model(2'd3, 32'd99999, 32'd13, eh, el, ez);
        checks++;
        if ({h, l, z} !== {eh, el, ez} || lat !== 33 || !bok) begin
            errors++;
            $display("FAIL after_reset: got hi=%h lo=%h lat=%0d want %h %h 33", h, l, lat, eh, el);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2; bit b1, b2; logic [31:0] h1, l1, h2, l2; logic z1, z2;
        do_op(2'd3, 32'd17, 32'd5, lat1, b1, h1, l1, z1);
        do_op(2'd1, 32'd6, 32'd7, lat2, b2, h2, l2, z2);
        checks++;
        if ({h1, l1} !== {32'd2, 32'd3} || lat1 !== 33) begin
            errors++;
            $display("FAIL b2b_first: got hi=%h lo=%h lat=%0d want 2 3 33", h1, l1, lat1);
        end
        checks++;
        if ({h2, l2} !== {32'd0, 32'd42} || lat2 !== 33 || !b2) begin
            errors++;
            $display("FAIL b2b_second: got hi=%h lo=%h lat=%0d want 0 2A 33", h2, l2, lat2);
        end
    endtask

    task automatic test_random();
        int lat; bit bok; logic [31:0] a, b, h, l, eh, el; logic z, ez; logic [1:0] o;
        for (int i = 0; i < 48; i++) begin
            o = 2'($urandom);
            case ($urandom_range(0, 5))
                0: begin a = $urandom; b = 0; end
                1: begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
                2: begin a = 32'h8000_0000; b = (i % 2) ? 32'hFFFF_FFFF : $urandom; end
                3: begin a = -$urandom_range(1, 1000); b = -$urandom_range(1, 50); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            do_op(o, a, b, lat, bok, h, l, z);
            model(o, a, b, eh, el, ez);
            checks++;
            if ({h, l, z} !== {eh, el, ez} || lat !== 33 || !bok) begin
                errors++;
                $display("FAIL random op=%0d a=%h b=%h: got hi=%h lo=%h dz=%b lat=%0d busy_ok=%0d want %h %h %b 33",
                         o, a, b, h, l, z, lat, bok, eh, el, ez);
            end
            if (i % 3 == 0) begin
                @(posedge clock); #1;
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_multu_max();
        test_signed();
        test_div_zero();
        test_busy_ignore();
        test_write_with_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
